// File: rtl/branch_predictor_if.sv
// Branch predictor <-> datapath bus: IF fetch view, MEM resolution view, predictor outputs.
interface branch_predictor_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] instr_F;
    logic [DATA_WIDTH-1:0] pc_F;
    logic                  load_use_flag;
    logic                  pcsrc;
    logic [7:0]            branch_M;
    logic [DATA_WIDTH-1:0] pc_M;
    logic                  pre_branch;
    logic                  prediction;
    logic [DATA_WIDTH-1:0] label;
    logic                  correct;
    logic                  error;
    logic [DATA_WIDTH-1:0] new_label;
    logic [31:0]           branch_count;
    logic [31:0]           mispredict_count;

    // Datapath side: supplies fetch/resolution info, consumes predictions.
    modport master (
        output instr_F, pc_F, load_use_flag, pcsrc, branch_M, pc_M,
        input  pre_branch, prediction, label, correct, error, new_label,
               branch_count, mispredict_count
    );

    // Predictor side.
    modport slave (
        input  instr_F, pc_F, load_use_flag, pcsrc, branch_M, pc_M,
        output pre_branch, prediction, label, correct, error, new_label,
               branch_count, mispredict_count
    );
endinterface

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: 2-bit BHT lookup in IF, prediction tracking to MEM,
// resolution/redirect signalling, BHT training and statistics.
module branch_predictor #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned BHT_IDX_BITS = 4
) (
    input logic              clk,
    input logic              rst,
    branch_predictor_if.slave bus
);
    localparam int unsigned BHT_DEPTH = 2 ** BHT_IDX_BITS;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;
    localparam logic [6:0]  OP_JAL    = 7'b1101111;

    logic [BHT_DEPTH-1:0][1:0] bht;

    logic valid_d, taken_d;
    logic valid_e, taken_e;
    logic valid_m, taken_m;
    logic [31:0] branch_cnt;
    logic [31:0] mispredict_cnt;

    logic                    is_b;
    logic                    is_jal;
    logic [DATA_WIDTH-1:0]   imm_b;
    logic [DATA_WIDTH-1:0]   imm_j;
    logic [BHT_IDX_BITS-1:0] idx_f;
    logic [BHT_IDX_BITS-1:0] idx_m;
    logic                    correct_w;
    logic                    error_w;
    logic                    redirect;
    logic                    pre_branch_w;
    logic                    prediction_w;

    // IF decode and MEM resolution.
    always_comb begin
        is_b   = (bus.instr_F[6:0] == OP_BRANCH);
        is_jal = (bus.instr_F[6:0] == OP_JAL);
        imm_b  = {{(DATA_WIDTH-12){bus.instr_F[31]}}, bus.instr_F[7],
                  bus.instr_F[30:25], bus.instr_F[11:8], 1'b0};
        imm_j  = {{(DATA_WIDTH-20){bus.instr_F[31]}}, bus.instr_F[19:12],
                  bus.instr_F[20], bus.instr_F[30:21], 1'b0};
        idx_f  = bus.pc_F[BHT_IDX_BITS+1:2];
        idx_m  = bus.pc_M[BHT_IDX_BITS+1:2];

        correct_w = valid_m & taken_m & bus.pcsrc;
        error_w   = valid_m & taken_m & ~bus.pcsrc;
        // MEM redirect outranks any IF redirect in the same cycle.
        redirect  = (bus.pcsrc & ~correct_w) | error_w;

        pre_branch_w = ~redirect & (is_b | is_jal);
        prediction_w = ~redirect & (is_jal | bht[idx_f][1]);
    end

    // Drive the bus outputs.
    always_comb begin
        bus.pre_branch       = pre_branch_w;
        bus.prediction       = prediction_w;
        bus.label            = '0;
        if (pre_branch_w) begin
            bus.label = bus.pc_F + (is_jal ? imm_j : imm_b);
        end
        bus.correct          = correct_w;
        bus.error            = error_w;
        bus.new_label        = bus.pc_M + DATA_WIDTH'(4);
        bus.branch_count     = branch_cnt;
        bus.mispredict_count = mispredict_cnt;
    end

    // Prediction pipeline F->D->E->M; redirect flushes, load-use holds D and bubbles E.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_d <= 1'b0; taken_d <= 1'b0;
            valid_e <= 1'b0; taken_e <= 1'b0;
            valid_m <= 1'b0; taken_m <= 1'b0;
        end else if (redirect) begin
            valid_d <= 1'b0; taken_d <= 1'b0;
            valid_e <= 1'b0; taken_e <= 1'b0;
            valid_m <= 1'b0; taken_m <= 1'b0;
        end else begin
            valid_m <= valid_e;
            taken_m <= taken_e;
            if (bus.load_use_flag) begin
                valid_e <= 1'b0;
                taken_e <= 1'b0;
            end else begin
                valid_e <= valid_d;
                taken_e <= taken_d;
                valid_d <= pre_branch_w;
                taken_d <= prediction_w;
            end
        end
    end

    // BHT training on resolved conditional branches (saturating 2-bit counters).
    always_ff @(posedge clk) begin
        if (rst) begin
            bht <= {BHT_DEPTH{2'b01}};
        end else if (valid_m && (bus.branch_M[5:0] != 6'd0)) begin
            if (bus.pcsrc && (bht[idx_m] != 2'b11)) begin
                bht[idx_m] <= bht[idx_m] + 2'd1;
            end else if (!bus.pcsrc && (bht[idx_m] != 2'b00)) begin
                bht[idx_m] <= bht[idx_m] - 2'd1;
            end
        end
    end

    // Branch and misprediction statistics, free-running and wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            branch_cnt     <= 32'd0;
            mispredict_cnt <= 32'd0;
        end else if (valid_m) begin
            branch_cnt <= branch_cnt + 32'd1;
            if (taken_m != bus.pcsrc) begin
                mispredict_cnt <= mispredict_cnt + 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_branch_predictor;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    branch_predictor_if #(.DATA_WIDTH(32)) bus ();

    branch_predictor #(.DATA_WIDTH(32), .BHT_IDX_BITS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    typedef struct {
        logic        pre;
        logic        pred;
        logic [31:0] label;
        logic        cor;
        logic        err;
        logic [31:0] nl;
    } exp_t;

    int          m_bht [16];   // counter value 0..3 per entry
    bit          m_v [3];      // in-flight predictions: 0=D, 1=E, 2=M
    bit          m_t [3];
    logic [31:0] m_bc;
    logic [31:0] m_mc;

    function automatic int decode_imm(input logic [31:0] ins);
        int v;
        if (ins[6:0] == 7'h6f) begin
            v = (ins[31] ? -1048576 : 0) + int'(ins[19:12]) * 4096
                + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
        end else begin
            v = (ins[31] ? -4096 : 0) + int'(ins[7]) * 2048
                + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
        end
        return v;
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        bit   is_b, is_j, redir;
        int   idx;
        is_b  = (bus.instr_F[6:0] == 7'h63);
        is_j  = (bus.instr_F[6:0] == 7'h6f);
        e.cor = m_v[2] && m_t[2] && bus.pcsrc;
        e.err = m_v[2] && m_t[2] && !bus.pcsrc;
        redir = (bus.pcsrc && !e.cor) || e.err;
        idx   = int'((bus.pc_F >> 2) % 16);
        e.pre  = !redir && (is_b || is_j);
        e.pred = !redir && (is_j || m_bht[idx] >= 2);
        e.label = e.pre ? bus.pc_F + 32'(decode_imm(bus.instr_F)) : 32'd0;
        e.nl   = bus.pc_M + 32'd4;
        return e;
    endfunction

    // Advance the model on each rising edge using the inputs present at that edge.
    always @(posedge clk) begin
        exp_t e;
        bit   redir;
        int   idx;
        e = model_out();
        if (rst) begin
            for (int i = 0; i < 16; i++) m_bht[i] = 1;
            for (int i = 0; i < 3; i++) begin m_v[i] = 0; m_t[i] = 0; end
            m_bc = 0;
            m_mc = 0;
        end else begin
            redir = (bus.pcsrc && !e.cor) || e.err;
            if (m_v[2]) begin
                m_bc = m_bc + 1;
                if (m_t[2] != bus.pcsrc) m_mc = m_mc + 1;
                if (bus.branch_M[5:0] != 0) begin
                    idx = int'((bus.pc_M >> 2) % 16);
                    if (bus.pcsrc) m_bht[idx] = (m_bht[idx] < 3) ? m_bht[idx] + 1 : 3;
                    else           m_bht[idx] = (m_bht[idx] > 0) ? m_bht[idx] - 1 : 0;
                end
            end
            if (redir) begin
                for (int i = 0; i < 3; i++) begin m_v[i] = 0; m_t[i] = 0; end
            end else begin
                m_v[2] = m_v[1]; m_t[2] = m_t[1];
                if (bus.load_use_flag) begin
                    m_v[1] = 0; m_t[1] = 0;
                end else begin
                    m_v[1] = m_v[0]; m_t[1] = m_t[0];
                    m_v[0] = e.pre;  m_t[0] = e.pred;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Compare process: DUT versus model every cycle, away from the active edge.
    bit model_ready = 0;
    always @(negedge clk) begin
        exp_t e;
        if (model_ready) begin
            e = model_out();
            chk("m_pre_branch", 32'(bus.pre_branch), 32'(e.pre));
            chk("m_prediction", 32'(bus.prediction), 32'(e.pred));
            chk("m_label",      bus.label,           e.label);
            chk("m_correct",    32'(bus.correct),    32'(e.cor));
            chk("m_error",      32'(bus.error),      32'(e.err));
            chk("m_new_label",  bus.new_label,       e.nl);
            chk("m_branch_cnt", bus.branch_count,    m_bc);
            chk("m_mispr_cnt",  bus.mispredict_count, m_mc);
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [31:0] enc_b(input logic [12:0] imm);
        logic [31:0] i;
        i = 32'h0000_0063;
        i[31] = imm[12]; i[30:25] = imm[10:5]; i[11:8] = imm[4:1]; i[7] = imm[11];
        return i;
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm);
        logic [31:0] i;
        i = 32'h0000_006f;
        i[31] = imm[20]; i[30:21] = imm[10:1]; i[20] = imm[11]; i[19:12] = imm[19:12];
        return i;
    endfunction

    // One cycle: drive after the edge, return just after the falling edge.
    task automatic cyc(input logic [31:0] ins, input logic [31:0] pcf, input logic lu,
                       input logic ps, input logic [7:0] bm, input logic [31:0] pcm,
                       input logic r);
        @(posedge clk);
        #1;
        bus.instr_F = ins; bus.pc_F = pcf; bus.load_use_flag = lu;
        bus.pcsrc = ps; bus.branch_M = bm; bus.pc_M = pcm; rst = r;
        @(negedge clk);
        #1;
    endtask

    task automatic nop_cyc();
        cyc(NOP, 32'h400, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0);
    endtask

    logic [31:0] beq100, jal200;

    initial begin
        logic [31:0] ins, pcf, pcm;
        logic [7:0]  bm;
        bus.instr_F = NOP; bus.pc_F = 32'h0; bus.load_use_flag = 1'b0;
        bus.pcsrc = 1'b0; bus.branch_M = 8'h0; bus.pc_M = 32'h0;
        beq100 = enc_b(13'h020);
        jal200 = enc_j(21'h000040);

        cyc(NOP, 32'h0, 1'b0, 1'b0, 8'h0, 32'h0, 1'b1);
        cyc(NOP, 32'h0, 1'b0, 1'b0, 8'h0, 32'h0, 1'b1);
        model_ready = 1;

        // 1: beq after reset, weakly not-taken
        cyc(beq100, 32'h100, 1'b0, 1'b0, 8'h0, 32'h0, 1'b0);
        chk("t1_pre_branch", 32'(bus.pre_branch), 32'd1);
        chk("t1_prediction", 32'(bus.prediction), 32'd0);
        chk("t1_label", bus.label, 32'h120);
        chk("t1_correct", 32'(bus.correct), 32'd0);
        chk("t1_error", 32'(bus.error), 32'd0);
        chk("t1_branch_cnt", bus.branch_count, 32'd0);
        cyc(NOP, 32'h0, 1'b0, 1'b0, 8'h0, 32'h0, 1'b1);

        // 2: JAL predicted taken, confirmed in MEM three cycles later
        cyc(jal200, 32'h200, 1'b0, 1'b0, 8'h0, 32'h0, 1'b0);
        chk("t2_prediction", 32'(bus.prediction), 32'd1);
        chk("t2_label", bus.label, 32'h240);
        nop_cyc(); nop_cyc();
        cyc(NOP, 32'h400, 1'b0, 1'b1, 8'h40, 32'h200, 1'b0);
        chk("t2_correct", 32'(bus.correct), 32'd1);
        chk("t2_error", 32'(bus.error), 32'd0);
        chk("t2_new_label", bus.new_label, 32'h204);
        nop_cyc();
        chk("t2_branch_cnt", bus.branch_count, 32'd1);
        chk("t2_mispr_cnt", bus.mispredict_count, 32'd0);

        // 3: beq trained taken twice
        cyc(beq100, 32'h100, 1'b0, 1'b0, 8'h0, 32'h0, 1'b0);
        chk("t3_pred_first", 32'(bus.prediction), 32'd0);
        nop_cyc(); nop_cyc();
        cyc(NOP, 32'h400, 1'b0, 1'b1, 8'h01, 32'h100, 1'b0);
        chk("t3_correct_nt", 32'(bus.correct), 32'd0);
        chk("t3_error_nt", 32'(bus.error), 32'd0);
        nop_cyc();
        chk("t3_mispr_1", bus.mispredict_count, 32'd1);
        cyc(beq100, 32'h100, 1'b0, 1'b0, 8'h0, 32'h0, 1'b0);
        chk("t3_pred_second", 32'(bus.prediction), 32'd1);
        nop_cyc(); nop_cyc();
        cyc(NOP, 32'h400, 1'b0, 1'b1, 8'h01, 32'h100, 1'b0);
        chk("t3_correct_t", 32'(bus.correct), 32'd1);
        cyc(beq100, 32'h100, 1'b0, 1'b0, 8'h0, 32'h0, 1'b0);
        chk("t3_pred_third", 32'(bus.prediction), 32'd1);
        chk("t3_label_third", bus.label, 32'h120);
        chk("t3_mispr_still1", bus.mispredict_count, 32'd1);
        chk("t3_branch_cnt", bus.branch_count, 32'd3);

        // 4: predicted-taken beq resolves not taken
        nop_cyc(); nop_cyc();
        cyc(beq100, 32'h100, 1'b0, 1'b0, 8'h01, 32'h100, 1'b0);
        chk("t4_error", 32'(bus.error), 32'd1);
        chk("t4_correct", 32'(bus.correct), 32'd0);
        chk("t4_new_label", bus.new_label, 32'h104);
        chk("t4_pre_forced", 32'(bus.pre_branch), 32'd0);
        nop_cyc();
        chk("t4_mispr_2", bus.mispredict_count, 32'd2);
        chk("t4_branch_cnt", bus.branch_count, 32'd4);
        cyc(beq100, 32'h100, 1'b0, 1'b0, 8'h0, 32'h0, 1'b0);
        chk("t4_bht_10", 32'(bus.prediction), 32'd1);

        // 5: unpredicted taken in MEM overrides a JAL in IF and flushes in-flight beq
        cyc(jal200, 32'h200, 1'b0, 1'b1, 8'h80, 32'h300, 1'b0);
        chk("t5_correct", 32'(bus.correct), 32'd0);
        chk("t5_pre_branch", 32'(bus.pre_branch), 32'd0);
        chk("t5_prediction", 32'(bus.prediction), 32'd0);
        chk("t5_label", bus.label, 32'h0);
        nop_cyc();
        cyc(NOP, 32'h400, 1'b0, 1'b0, 8'h01, 32'h100, 1'b0);
        chk("t5_flushed_err", 32'(bus.error), 32'd0);
        cyc(NOP, 32'h400, 1'b0, 1'b1, 8'h40, 32'h200, 1'b0);
        chk("t5_flushed_cor", 32'(bus.correct), 32'd0);
        chk("t5_branch_cnt", bus.branch_count, 32'd4);

        // 6: load-use stall delays the prediction by one cycle
        cyc(beq100, 32'h100, 1'b0, 1'b0, 8'h0, 32'h0, 1'b0);
        chk("t6_pred", 32'(bus.prediction), 32'd1);
        cyc(NOP, 32'h400, 1'b1, 1'b0, 8'h0, 32'h0, 1'b0);
        nop_cyc();
        cyc(NOP, 32'h400, 1'b0, 1'b0, 8'h01, 32'h100, 1'b0);
        chk("t6_not_yet", 32'(bus.error), 32'd0);
        cyc(NOP, 32'h400, 1'b0, 1'b1, 8'h01, 32'h100, 1'b0);
        chk("t6_arrived", 32'(bus.correct), 32'd1);

        // 6b: reset mid-run with a full pipeline
        cyc(beq100, 32'h100, 1'b0, 1'b0, 8'h0, 32'h0, 1'b0);
        cyc(jal200, 32'h200, 1'b0, 1'b0, 8'h0, 32'h0, 1'b0);
        cyc(NOP, 32'h400, 1'b0, 1'b0, 8'h0, 32'h0, 1'b1);
        cyc(beq100, 32'h100, 1'b0, 1'b0, 8'h0, 32'h0, 1'b0);
        chk("t6_rst_bht", 32'(bus.prediction), 32'd0);
        chk("t6_rst_bcnt", bus.branch_count, 32'd0);
        chk("t6_rst_mcnt", bus.mispredict_count, 32'd0);
        cyc(NOP, 32'h400, 1'b0, 1'b0, 8'h01, 32'h100, 1'b0);
        chk("t6_rst_err", 32'(bus.error), 32'd0);
        cyc(NOP, 32'h400, 1'b0, 1'b1, 8'h40, 32'h200, 1'b0);
        chk("t6_rst_cor", 32'(bus.correct), 32'd0);

        // Randomized traffic with aliasing PCs
        for (int n = 0; n < 3000; n++) begin
            ins = $urandom;
            case ($urandom_range(0, 3))
                0: ins[6:0] = 7'h63;
                1: ins[6:0] = 7'h6f;
                2: ins[6:0] = 7'h67;
                default: ;
            endcase
            pcf = ($urandom_range(0, 7) == 0) ? $urandom : 32'h100 + 32'($urandom_range(0, 31)) * 4;
            pcm = 32'h100 + 32'($urandom_range(0, 31)) * 4;
            bm  = 8'h00;
            if ($urandom_range(0, 8) != 8) bm = 8'h01 << $urandom_range(0, 7);
            cyc(ins, pcf, ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), bm, pcm,
                ($urandom_range(0, 199) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Dynamic branch predictor and redirect controller for the 5-stage RISC-V pipeline.
- In IF: decodes the fetched instruction, looks up a 2-bit saturating-counter branch history table (BHT) and drives pre_branch/prediction/label into the datapath PC muxes.
- Carries each prediction down to MEM, compares it with the resolved outcome (pcsrc), and drives correct/error/new_label.
- Trains the BHT at resolution and keeps branch and mispredict statistics.

Parameters:
DATA_WIDTH, 32, width of PC, instruction and label buses
BHT_IDX_BITS, 4, log2 of BHT entries (16); index = PC[BHT_IDX_BITS+1:2]

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
instr_F  input  DATA_WIDTH  instruction fetched at pc_F
pc_F  input  DATA_WIDTH  current fetch PC (datapath pc)
load_use_flag  input  1  load-use stall: hold IF/ID, bubble into ID/EX
pcsrc  input  1  resolved branch/jump taken in MEM (from datapath)
branch_M  input  8  MEM branch type one-hot; [5:0] conditional, [6] JAL, [7] JALR
pc_M  input  DATA_WIDTH  PC of instruction in MEM
pre_branch  output  1  instr_F is B-type or JAL
prediction  output  1  predict taken for instr_F
label  output  DATA_WIDTH  predicted target = pc_F + imm
correct  output  1  MEM instruction was predicted taken and is taken
error  output  1  MEM instruction was predicted taken but not taken
new_label  output  DATA_WIDTH  recovery PC = pc_M + 4
branch_count  output  32  resolved predicted instructions (wraps)
mispredict_count  output  32  resolved mispredictions of either direction (wraps)

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset:
  - all BHT entries = 2'b01 (weakly not taken);
  - pipeline flags and counters = 0;
  - error and correct = 0.
- IF decode, combinational:
  - B-type is opcode 7'b1100011; imm = {sext(instr[31]), instr[7], instr[30:25], instr[11:8], 1'b0}.
  - JAL is opcode 7'b1101111; imm = {sext(instr[31]), instr[19:12], instr[20], instr[30:21], 1'b0}.
  - JALR is never predicted.
- IF outputs:
  - label = pc_F + imm, mod 2^DATA_WIDTH; label = 0 when pre_branch = 0.
  - pre_branch = B-type or JAL.
  - prediction = JAL ? 1 : BHT[pc_F idx][1].
  - redirect = (pcsrc & ~correct) | error.
  - When redirect = 1, pre_branch and prediction are forced to 0 so the MEM redirect wins over the IF redirect.
- Prediction pipeline: per-stage {valid, taken} for D, E and M.
  - F to D latch:
    - loads {pre_branch, prediction} when no stall;
    - holds when load_use_flag = 1;
    - clears on redirect.
  - D to E: clears on redirect or load_use_flag.
  - E to M: clears on redirect.
  - Redirect has priority over stall.
- Resolution in MEM, combinational:
  - correct = valid_M & taken_M & pcsrc.
  - error = valid_M & taken_M & ~pcsrc.
  - new_label = pc_M + 4.
  - Predicted not-taken but taken gives correct = 0 and error = 0; the datapath takes its pcsrc path.
- BHT update: on the clock edge when valid_M & |branch_M[5:0], entry[pc_M idx] saturates up if pcsrc, down otherwise.
  - 11 + taken stays 11.
  - 00 + not-taken stays 00.
  - A same-cycle IF read of the same index returns the old value.
- Counters:
  - branch_count increments when valid_M.
  - mispredict_count increments when valid_M & (taken_M != pcsrc).
  - Both wrap at 2^32.
- Reset mid-operation: flags, counters and BHT are reinitialised at the next edge; no stale correct or error after reset.

Test Plan:
1. Reset, then beq at pc_F=0x100, imm=+0x20 -> pre_branch=1, prediction=0, label=0x120; correct and error stay 0; counters 0.
2. JAL at pc_F=0x200, imm=+0x40 -> prediction=1, label=0x240; 3 cycles later pcsrc=1 -> correct=1, error=0, branch_count=1.
3. beq at 0x100 resolved taken twice (BHT 01->10->11) -> third fetch of 0x100 gives prediction=1, label=0x120; mispredict_count=1 after the first resolution, unchanged by the second.
4. Predicted-taken beq at pc_M=0x100 resolves pcsrc=0 -> error=1, new_label=0x104; next cycle valid_D/E/M=0; BHT entry 11->10; mispredict_count+1.
5. pcsrc=1 with correct=0 in the same cycle as a JAL in IF -> pre_branch=0, prediction=0; F/D/E/M flags cleared.
6. load_use_flag=1 for 1 cycle behind a predicted beq -> prediction reaches MEM one cycle later; rst asserted mid-run -> all outputs 0 and BHT back to 01 next cycle.
